// File: rtl/i2c_deglitch_sync.sv
// i2c_deglitch_sync
// Multi-channel glitch filter for I2C pad inputs (SCL = bit 0, SDA = bit 1).
// Each channel is synchronised through SYNC_STAGES flops (legal range 2..4),
// then a persistence counter lets a level change reach o_out only after it
// has held for L = max(i_flt_len, 1) clocks. Rejected pulses raise o_glitch,
// accepted changes raise o_rise / o_fall in the first cycle o_out shows them.
// i_byp skips qualification: o_out follows the synchronised input directly.
module i2c_deglitch_sync #(
    parameter int NCH         = 2,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [NCH-1:0]   i_in,
    input  logic             i_byp,
    input  logic [CNT_W-1:0] i_flt_len,
    output logic [NCH-1:0]   o_out,
    output logic [NCH-1:0]   o_rise,
    output logic [NCH-1:0]   o_fall,
    output logic [NCH-1:0]   o_glitch
);

    logic [SYNC_STAGES-1:0] r_sync [NCH];
    logic [CNT_W-1:0]       r_cnt  [NCH];
    logic [NCH-1:0]         r_out;
    logic [NCH-1:0]         r_rise;
    logic [NCH-1:0]         r_fall;
    logic [NCH-1:0]         r_glitch;

    logic [NCH-1:0]         w_s;
    logic [CNT_W-1:0]       w_len_m1;
    logic [CNT_W-1:0]       w_cnt_nxt [NCH];
    logic [NCH-1:0]         w_out_nxt;
    logic [NCH-1:0]         w_rise_nxt;
    logic [NCH-1:0]         w_fall_nxt;
    logic [NCH-1:0]         w_glitch_nxt;

    // Terminal count L-1; a programmed length of 0 behaves like 1.
    assign w_len_m1 = (i_flt_len == '0) ? '0 : (i_flt_len - 1'b1);

    // Synchronisers reset high because the I2C bus idles high.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < NCH; i++) begin
                r_sync[i] <= '1;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                r_sync[i] <= {r_sync[i][SYNC_STAGES-2:0], i_in[i]};
            end
        end
    end

    // Last synchroniser stage is the clean per-channel sample.
    always_comb begin
        w_s = '0;
        for (int i = 0; i < NCH; i++) begin
            w_s[i] = r_sync[i][SYNC_STAGES-1];
        end
    end

    // Per-channel qualification: commit, count, or report a rejected pulse.
    always_comb begin
        w_out_nxt    = r_out;
        w_rise_nxt   = '0;
        w_fall_nxt   = '0;
        w_glitch_nxt = '0;
        for (int i = 0; i < NCH; i++) begin
            w_cnt_nxt[i] = r_cnt[i];
            if (i_byp) begin
                // Pending counts are dropped silently; no glitch in bypass.
                w_out_nxt[i]  = w_s[i];
                w_cnt_nxt[i]  = '0;
                w_rise_nxt[i] = w_s[i] & ~r_out[i];
                w_fall_nxt[i] = ~w_s[i] & r_out[i];
            end else if (w_s[i] != r_out[i]) begin
                if (r_cnt[i] >= w_len_m1) begin
                    w_out_nxt[i]  = w_s[i];
                    w_cnt_nxt[i]  = '0;
                    w_rise_nxt[i] = w_s[i];
                    w_fall_nxt[i] = ~w_s[i];
                end else begin
                    // Cannot wrap: the commit branch fires at L-1 at the latest.
                    w_cnt_nxt[i] = r_cnt[i] + 1'b1;
                end
            end else if (r_cnt[i] != '0) begin
                w_cnt_nxt[i]    = '0;
                w_glitch_nxt[i] = 1'b1;
            end
        end
    end

    // Filter state and registered strobes.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < NCH; i++) begin
                r_cnt[i] <= '0;
            end
            r_out    <= '1;
            r_rise   <= '0;
            r_fall   <= '0;
            r_glitch <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
            r_out    <= w_out_nxt;
            r_rise   <= w_rise_nxt;
            r_fall   <= w_fall_nxt;
            r_glitch <= w_glitch_nxt;
        end
    end

    assign o_out    = r_out;
    assign o_rise   = r_rise;
    assign o_fall   = r_fall;
    assign o_glitch = r_glitch;

endmodule

// File: tb/tb_i2c_deglitch_sync.sv
// Directed bench for i2c_deglitch_sync (NCH=2, SYNC_STAGES=2, CNT_W=4).
// Vector semantics: apply inputs, advance one rising edge, sample 1 time unit
// later and compare {out, rise, fall, glitch} against the hand-computed value.
module tb_i2c_deglitch_sync;

    localparam int NCH   = 2;
    localparam int SYNC  = 2;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst;
    logic [NCH-1:0]   in_r;
    logic             byp;
    logic [CNT_W-1:0] flt_len;
    logic [NCH-1:0]   out_w;
    logic [NCH-1:0]   rise_w;
    logic [NCH-1:0]   fall_w;
    logic [NCH-1:0]   glitch_w;

    int n_tests = 0;
    int n_fail  = 0;
    int scn     = 0;

    typedef struct {
        logic [1:0] in;
        logic       byp;
        logic [3:0] len;
        logic [7:0] exp;   // {out, rise, fall, glitch}
        int         scn;
    } vec_t;

    vec_t vecs[$];

    i2c_deglitch_sync #(
        .NCH(NCH),
        .SYNC_STAGES(SYNC),
        .CNT_W(CNT_W)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_in(in_r),
        .i_byp(byp),
        .i_flt_len(flt_len),
        .o_out(out_w),
        .o_rise(rise_w),
        .o_fall(fall_w),
        .o_glitch(glitch_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] exp);
        logic [7:0] act;
        act = {out_w, rise_w, fall_w, glitch_w};
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s {out,rise,fall,glitch} got=%b_%b_%b_%b want=%b_%b_%b_%b",
                     name, act[7:6], act[5:4], act[3:2], act[1:0],
                     exp[7:6], exp[5:4], exp[3:2], exp[1:0]);
        end
    endtask

    task automatic add(input logic [1:0] in, input logic b, input logic [3:0] len,
                       input logic [1:0] o, input logic [1:0] r, input logic [1:0] f,
                       input logic [1:0] g, input int n);
        vec_t v;
        v.in  = in;
        v.byp = b;
        v.len = len;
        v.exp = {o, r, f, g};
        v.scn = scn;
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endtask

    task automatic idle(input logic b, input logic [3:0] len, input int n);
        add(2'b11, b, len, 2'b11, 2'b00, 2'b00, 2'b00, n);
    endtask

    initial begin
        // ---------------- vector table ----------------
        scn = 0; idle(0, 4, 3);
        // reject: IN[1] low 3 clocks
        scn = 1;
        add(2'b01, 0, 4, 2'b11, 2'b00, 2'b00, 2'b00, 3);
        idle(0, 4, 2);
        add(2'b11, 0, 4, 2'b11, 2'b00, 2'b00, 2'b10, 1);
        idle(0, 4, 2);
        // pass: IN[1] low 4 clocks, then high 10
        scn = 2;
        add(2'b01, 0, 4, 2'b11, 2'b00, 2'b00, 2'b00, 4);
        idle(0, 4, 1);
        add(2'b11, 0, 4, 2'b01, 2'b00, 2'b10, 2'b00, 1);
        add(2'b11, 0, 4, 2'b01, 2'b00, 2'b00, 2'b00, 3);
        add(2'b11, 0, 4, 2'b11, 2'b10, 2'b00, 2'b00, 1);
        idle(0, 4, 4);
        // FLT_LEN=0: 1-clock pulse on IN[0] passes
        scn = 3;
        add(2'b10, 0, 0, 2'b11, 2'b00, 2'b00, 2'b00, 1);
        idle(0, 0, 1);
        add(2'b11, 0, 0, 2'b10, 2'b00, 2'b01, 2'b00, 1);
        add(2'b11, 0, 0, 2'b11, 2'b01, 2'b00, 2'b00, 1);
        idle(0, 0, 2);
        // FLT_LEN=15: 14-clock pulse rejected
        scn = 4;
        add(2'b10, 0, 15, 2'b11, 2'b00, 2'b00, 2'b00, 14);
        idle(0, 15, 2);
        add(2'b11, 0, 15, 2'b11, 2'b00, 2'b00, 2'b01, 1);
        idle(0, 15, 1);
        // FLT_LEN=15: 15-clock pulse passes
        scn = 5;
        add(2'b10, 0, 15, 2'b11, 2'b00, 2'b00, 2'b00, 15);
        idle(0, 15, 1);
        add(2'b11, 0, 15, 2'b10, 2'b00, 2'b01, 2'b00, 1);
        add(2'b11, 0, 15, 2'b10, 2'b00, 2'b00, 2'b00, 14);
        add(2'b11, 0, 15, 2'b11, 2'b01, 2'b00, 2'b00, 1);
        idle(0, 15, 1);
        // bypass: 1-clock low pulse on IN[0]
        scn = 6;
        add(2'b10, 1, 4, 2'b11, 2'b00, 2'b00, 2'b00, 1);
        idle(1, 4, 1);
        add(2'b11, 1, 4, 2'b10, 2'b00, 2'b01, 2'b00, 1);
        add(2'b11, 1, 4, 2'b11, 2'b01, 2'b00, 2'b00, 1);
        idle(1, 4, 1);
        // BYP 0->1 with cnt=2, then 1->0 while idle
        scn = 7;
        add(2'b10, 0, 4, 2'b11, 2'b00, 2'b00, 2'b00, 4);
        add(2'b10, 1, 4, 2'b10, 2'b00, 2'b01, 2'b00, 1);
        add(2'b10, 1, 4, 2'b10, 2'b00, 2'b00, 2'b00, 1);
        add(2'b11, 1, 4, 2'b10, 2'b00, 2'b00, 2'b00, 2);
        add(2'b11, 1, 4, 2'b11, 2'b01, 2'b00, 2'b00, 1);
        idle(1, 4, 1);
        idle(0, 4, 2);
        // simultaneous fall for 5 clocks
        scn = 8;
        add(2'b00, 0, 4, 2'b11, 2'b00, 2'b00, 2'b00, 5);
        add(2'b11, 0, 4, 2'b00, 2'b00, 2'b11, 2'b00, 1);
        add(2'b11, 0, 4, 2'b00, 2'b00, 2'b00, 2'b00, 4);
        add(2'b11, 0, 4, 2'b11, 2'b11, 2'b00, 2'b00, 1);
        idle(0, 4, 1);
        // FLT_LEN 8 -> 2 while cnt=3
        scn = 9;
        add(2'b00, 0, 8, 2'b11, 2'b00, 2'b00, 2'b00, 5);
        add(2'b00, 0, 2, 2'b00, 2'b00, 2'b11, 2'b00, 1);
        add(2'b00, 0, 2, 2'b00, 2'b00, 2'b00, 2'b00, 1);
        add(2'b11, 0, 2, 2'b00, 2'b00, 2'b00, 2'b00, 3);
        add(2'b11, 0, 2, 2'b11, 2'b11, 2'b00, 2'b00, 1);
        idle(0, 4, 2);

        // ---------------- reset ----------------
        rst = 1'b1; in_r = 2'b11; byp = 1'b0; flt_len = 4'd4;
        #3;
        check("reset_state", 8'b11_00_00_00);
        @(posedge clk); @(posedge clk); #3;
        rst = 1'b0;

        // reset mid-count: IN=00, cnt reaches 3, then async reset
        in_r = 2'b00;
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("pre_rst_cycle%0d", k), 8'b11_00_00_00);
        end
        #2; rst = 1'b1; #1;
        check("rst_async_midcount", 8'b11_00_00_00);
        tick();
        check("rst_held_over_edge", 8'b11_00_00_00);
        #2; rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("post_rst_cycle%0d", k), 8'b11_00_00_00);
        end
        tick();
        check("post_rst_fall", 8'b00_00_11_00);
        #2; rst = 1'b1; #1;
        check("rst_async_clears_strobe", 8'b11_00_00_00);
        in_r = 2'b11;
        @(posedge clk); #3;
        rst = 1'b0;
        tick();
        check("post_rst_idle", 8'b11_00_00_00);

        // ---------------- table ----------------
        for (int k = 0; k < vecs.size(); k++) begin
            in_r    = vecs[k].in;
            byp     = vecs[k].byp;
            flt_len = vecs[k].len;
            tick();
            check($sformatf("vec%0d_scn%0d", k, vecs[k].scn), vecs[k].exp);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_deglitch_sync.md
# i2c_deglitch_sync

Clocked, parametrised multi-channel glitch filter for the I2C pad inputs (SCL, SDA, and any extra open-drain lines). Each channel is synchronised into the `CLK` domain, then qualified by a per-channel persistence counter: a level change propagates only after it has held for a programmable number of clocks. The block sits between the pad receivers and the I2C bit/byte engines, replacing the analog latch-and-delay-line filter. It adds runtime filter length, per-channel edge strobes, glitch reporting and a clean bypass.

## Interface
- `NCH`, 2: number of independent channels. Bit 0 is SCL and bit 1 is SDA by convention.
- `SYNC_STAGES`, 2: synchroniser flops per channel. Legal range 2..4.
- `CNT_W`, 4: width of the filter-length control and the per-channel counters.

- `CLK`  in  1  system clock; all state updates on the rising edge.
- `RST`  in  1  asynchronous, active-high reset.
- `IN`  in  NCH  raw asynchronous pad inputs.
- `BYP`  in  1  bypass; 1 = output follows the synchronised input with no qualification.
- `FLT_LEN`  in  CNT_W  required persistence in clocks. A value of 0 is treated as 1. Quasi-static.
- `OUT`  out  NCH  filtered level per channel.
- `RISE`  out  NCH  one-cycle strobe, high in the cycle in which `OUT[i]` first reads 1 after being 0.
- `FALL`  out  NCH  one-cycle strobe, high in the cycle in which `OUT[i]` first reads 0 after being 1.
- `GLITCH`  out  NCH  one-cycle strobe when a rejected pulse ends on channel i.

## Operation
- **Per channel i, the registers are:**
  - `sync[i]`: SYNC_STAGES flops. The last stage is S[i].
  - `cnt[i]`: CNT_W bits.
  - `OUT[i]`, `RISE[i]`, `FALL[i]`, `GLITCH[i]`.
- **Reset values:**
  - All sync flops = 1 and `OUT` = all-ones, since the I2C idle level is high.
  - `cnt` = 0.
  - `RISE`, `FALL`, `GLITCH` = 0.
- **Effective length:** L = max(FLT_LEN, 1).
- **Filter, BYP=0.** Evaluated every edge, in priority order:
  1. If S[i] != OUT[i] and cnt[i] >= L-1: OUT[i] <= S[i], cnt[i] <= 0, and the matching RISE/FALL strobe is set.
  2. Else if S[i] != OUT[i]: cnt[i] <= cnt[i]+1. The counter cannot overflow because of rule 1.
  3. Else if cnt[i] != 0: cnt[i] <= 0 and GLITCH[i] <= 1. This is a rejected pulse.
  4. Else: no change.
- **Strobes:** RISE, FALL and GLITCH default to 0 every cycle unless set by the rules above, so each is one cycle wide. RISE and FALL are mutually exclusive per channel.
- **Bypass, BYP=1:**
  - OUT[i] <= S[i] every edge and cnt[i] <= 0.
  - RISE/FALL still strobe on every OUT change.
  - GLITCH stays 0.
- **BYP 1->0:** filtering resumes from cnt = 0 with the current OUT. No spurious strobe is generated.
- **BYP 0->1 mid-count:** the pending count is discarded and OUT takes S on the next edge. A strobe fires if the level differs. No GLITCH is reported.
- **FLT_LEN change mid-count:** the comparison always uses the current L. If cnt[i] >= new L-1 while differing, OUT updates on the next edge.
- **Channel independence:** channels are fully independent. Simultaneous events on several channels each produce their own strobes in the same cycle.

## Timing
- **Synchroniser latency:** an IN change that meets setup before edge 0 appears on S after SYNC_STAGES edges.
- **Filter latency:** OUT changes L edges after S first differs from OUT. Total IN-to-OUT latency is SYNC_STAGES + L clocks, plus up to 1 clock of synchroniser sampling uncertainty.
- **Pass/reject rule at S:**
  - A pulse held for >= L consecutive clocks passes.
  - A pulse held for <= L-1 clocks is rejected, and GLITCH asserts in the cycle after S returns.
- **Bypass latency:** SYNC_STAGES + 1 clocks.
- **Strobe alignment:** RISE and FALL are registered and are high exactly in the first cycle OUT shows the new value.
- **Mid-operation reset:** RST asserted at any time forces all reset values immediately, independent of CLK. The first update occurs on the first CLK edge after RST deasserts.

## Test plan
Bench parameters: NCH=2, SYNC_STAGES=2, FLT_LEN=4.

1. **Reset:** assert RST mid-count with IN=2'b00 -> OUT=2'b11, all strobes 0 immediately. After release, OUT[0] falls 6 clocks after the first sampling edge, with FALL[0]=1 for 1 cycle.
2. **Reject:** IN[1]=0 for 3 clocks then back to 1 -> OUT[1] stays 1, no FALL, GLITCH[1]=1 for exactly 1 cycle.
3. **Pass:** IN[1]=0 for 4 clocks -> OUT[1]=0 after 6 clocks, FALL[1] 1 cycle. IN[1] then returns to 1 for 10 clocks -> RISE[1] 1 cycle, OUT[1]=1.
4. **FLT_LEN=0 and FLT_LEN=15:** with FLT_LEN=0, a 1-clock pulse passes and OUT reproduces it 3 clocks later. With FLT_LEN=15, a 14-clock pulse is rejected and a 15-clock pulse passes.
5. **Bypass:** BYP=1 with a 1-clock low pulse on IN[0] -> OUT[0] low for 1 cycle, 3 clocks later, with FALL then RISE and no GLITCH. Switching BYP 0->1 when cnt=2 -> OUT updates next edge, no GLITCH.
6. **Simultaneous:** both channels fall together for 5 clocks -> FALL=2'b11 in the same cycle. Repeat with FLT_LEN lowered from 8 to 2 while cnt=3 -> OUT updates on the next edge.
